fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drain-side consumer for the team's 8-bit `fifo`. It watches `empty` and reads the head byte from the first-word-fall-through `pop_data`. It pops exactly one entry per frame and serialises the byte as an 8N1 UART frame on `tx`, or 8E1 when parity is compiled in. It sits between the FIFO's read port and the board TX pin, so software-side pushes turn into serial output with no further control logic.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, bit rate. `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer floor; must be ≥ 2).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst == 0` resets immediately, independent of `clk`).
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_pop_data`  in  8  FIFO head byte; valid whenever `fifo_empty == 0`.
- `fifo_pop`  out  1  one-cycle pop strobe to the FIFO `pop` input.
- `tx`  out  1  serial output; idle level 1.
- `tx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE**
  - `tx = 1`.
  - If `fifo_empty == 0` at a rising edge, that edge does all of the following: latches `fifo_pop_data` into the shift register, sets `fifo_pop <= 1`, clears the baud counter and bit index, and enters START.
- **START**
  - `tx = 0` for `CLKS_PER_BIT` cycles, then DATA.
- **DATA**
  - Shift-register bit 0 is driven on `tx`.
  - After each `CLKS_PER_BIT` cycles the register shifts right and the bit index increments.
  - After 8 bits (LSB first) go to PARITY if it is compiled in, otherwise STOP.
- **STOP**
  - `tx = 1` for `CLKS_PER_BIT` cycles, then IDLE.
- **Baud counter**
  - Width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT-1`, wraps to 0, and advances the FSM on the wrap.
- **FIFO-side rules**
  - `fifo_pop` is registered and high for exactly one cycle, namely the first START cycle.
  - `fifo_pop` is never asserted while in any state other than the transition out of IDLE.
  - `fifo_pop` is never asserted when `fifo_empty` was 1 at the load edge.
- **Data isolation**
  - The byte is latched before the pop, so FIFO pushes or head changes during a frame do not affect the frame in flight.
- **Outputs**
  - `tx` and `tx_busy` are registered, so there are no combinational glitches on the pin.

## Timing
- **Reset values:** `tx = 1`, `fifo_pop = 0`, `tx_busy = 0`, state IDLE, counters 0, shift register 0.
- **Latency:** the load edge is the edge at which IDLE sees `fifo_empty == 0`. `tx` falls and `tx_busy` rises in the cycle after that edge.
- **Frame length:** `10 × CLKS_PER_BIT` cycles, or 11 × with parity.
- **Back-to-back frames:** after STOP, exactly one IDLE cycle (`tx = 1`, `tx_busy = 0`) precedes the next load. Frame-to-frame period is therefore `10 × CLKS_PER_BIT + 1`, or 11 × with parity + 1.
- **Empty boundary:** if `fifo_empty` rises during a frame, the current frame completes and the block then stays in IDLE. If the FIFO becomes non-empty in the same cycle the block returns to IDLE, the load happens on the next edge.
- **Reset mid-frame:** `tx` returns to 1 and `tx_busy` to 0 asynchronously. The partially sent byte is lost because it was already popped. After `rst` rises, the block restarts from IDLE with the next FIFO entry.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- **Defined:** a PARITY state is inserted after DATA and drives even parity (`^data`) for `CLKS_PER_BIT` cycles, giving an 11-bit frame (8E1).
- **Undefined:** no PARITY state and no parity logic; 10-bit frame (8N1).

## Test plan
Benches use `CLK_FREQ = 1_000_000`, `BAUD = 100_000`, so `CLKS_PER_BIT = 10`.

1. **Reset/idle:** hold `rst = 0` for 2 cycles, then release with `fifo_empty = 1` for 200 cycles -> `tx = 1`, `fifo_pop = 0`, `tx_busy = 0` throughout.
2. **Single byte:** `fifo_pop_data = 8'h61`, `fifo_empty` falls for one entry -> one `fifo_pop` pulse. `tx` sequence, 10 cycles each: 0 | 1,0,0,0,0,1,1,0 | 1. `tx_busy` is high for exactly 100 cycles.
3. **Back-to-back:** a real `fifo` instance is preloaded with 8'h61..8'h65 -> exactly 5 pops. Consecutive falling start edges are 101 cycles apart, bytes decode in order a..e, and the block ends idle with FIFO empty.
4. **Parity (macro defined):** 8'h61 -> parity bit 1 at cycles 90–99 of the frame, frame length 110. 8'h00 -> parity bit 0.
5. **Reset mid-frame:** assert `rst = 0` during data bit 3 of 8'hAA -> `tx = 1` and `tx_busy = 0` within the same cycle. After release with 8'h55 at the FIFO head -> a clean 8'h55 frame.
6. **Data isolation:** change `fifo_pop_data` every cycle after the load edge of 8'h3C -> the serialised byte is still 8'h3C, and `fifo_pop` is asserted only once.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit first-word-fall-through FIFO and sends each byte as a UART frame (8N1).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data (8E1).
module fifo_uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_pop_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             pop_q, pop_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             baud_wrap;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign baud_wrap = (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pop_d    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Byte is captured on the same edge the pop is issued, isolating the frame.
                if (!fifo_empty) begin
                    shift_d  = fifo_pop_data;
                    pop_d    = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = S_START;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_d = ^fifo_pop_data;
`endif
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin-side outputs are decoded from the next state so they register glitch-free.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            pop_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            pop_q    <= pop_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo_pop = pop_q;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: behavioural FIFO, UART line decoder and scoreboard.
// Honours FIFO_UART_TX_PARITY_EN to expect 8E1 frames.
module tb_fifo_uart_tx;

    localparam int CPB = 10;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_CYC = 11 * CPB;
`else
    localparam int FRAME_CYC = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_pop_data;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int pops  = 0;
    logic       scramble = 1'b0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         start_q[$];

    fifo_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_pop_data(fifo_pop_data),
        .fifo_pop     (fifo_pop),
        .tx           (tx),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        if (scramble)
            fifo_pop_data = 8'($urandom);
        else
            fifo_pop_data = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
        refresh();
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (fifo_empty && !tx_busy) break;
        end
        check("idle_reached", (i < max_cyc), 1'b1);
        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic single_frame(input logic [7:0] b, input string tag);
        int n;
        int p0;
        p0 = pops;
        push(b);
        @(negedge clk);
        check({tag, "_tx_start"}, tx, 1'b0);
        check({tag, "_busy_rise"}, tx_busy, 1'b1);
        check({tag, "_pop_pulse"}, fifo_pop, 1'b1);
        n = 1;
        @(negedge clk);
        check({tag, "_pop_low"}, fifo_pop, 1'b0);
        if (tx_busy) n++;
        for (int i = 0; i < 300 && tx_busy; i++) begin
            @(negedge clk);
            if (tx_busy) n++;
        end
        check({tag, "_busy_len"}, n, FRAME_CYC);
        check({tag, "_pop_count"}, pops - p0, 1);
        wait_idle(50);
    endtask

    initial begin
        int bad;
        int p0;
        rst = 1'b0;
        refresh();
        fork
            // FIFO model: a pop seen during the cycle removes the head.
            forever begin
                @(negedge clk);
                cyc++;
                if (fifo_pop) begin
                    pops++;
                    check("pop_nonempty", (fq.size() != 0), 1'b1);
                    if (fq.size() != 0) void'(fq.pop_front());
                end
                refresh();
            end
            // UART line decoder: samples mid-bit, drops frames cut by reset.
            forever begin
                logic [7:0] b;
                logic [7:0] e;
                logic       s0, bz, stp, ab;
`ifdef FIFO_UART_TX_PARITY_EN
                logic       par;
`endif
                @(negedge tx);
                start_q.push_back(cyc);
                repeat (5) @(negedge clk);
                ab = !rst;
                s0 = tx;
                bz = tx_busy;
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        repeat (CPB) @(negedge clk);
                        ab = !rst;
                        b[i] = tx;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                if (!ab) begin
                    repeat (CPB) @(negedge clk);
                    ab = !rst;
                    par = tx;
                end
`endif
                if (!ab) begin
                    repeat (CPB) @(negedge clk);
                    ab = !rst;
                    stp = tx;
                end
                if (!ab) begin
                    check("start_bit", s0, 1'b0);
                    check("busy_in_frame", bz, 1'b1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_byte", b, e);
`ifdef FIFO_UART_TX_PARITY_EN
                        check("parity_bit", par, ^e);
`endif
                    end
                    check("stop_bit", stp, 1'b1);
                end
            end
        join_none

        // Reset and long idle with an empty FIFO.
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_pop", fifo_pop, 1'b0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_pop !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        check("idle_quiet_cycles", bad, 0);

        // Single bytes including all-zero / all-one patterns.
        single_frame(8'h61, "b61");
        single_frame(8'h00, "b00");
        single_frame(8'hFF, "bFF");

        // Back-to-back: five queued bytes, one idle cycle between frames.
        start_q.delete();
        p0 = pops;
        for (int i = 0; i < 5; i++) fq.push_back(8'h61 + 8'(i));
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h61 + 8'(i));
        refresh();
        wait_idle(5 * (FRAME_CYC + 1) + 20);
        check("b2b_pops", pops - p0, 5);
        check("b2b_frames", start_q.size(), 5);
        for (int i = 1; i < start_q.size(); i++)
            check("b2b_spacing", start_q[i] - start_q[i-1], FRAME_CYC + 1);

        // Reset during data bit 3 of 8'hAA, 8'h55 waiting behind it.
        p0 = pops;
        push(8'hAA);
        @(negedge clk);
        push(8'h55);
        repeat (44) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        void'(exp_q.pop_front());
        repeat (15) @(negedge clk);
        rst = 1'b1;
        wait_idle(FRAME_CYC + 20);
        check("midrst_pops", pops - p0, 2);

        // Head byte scrambled during the frame must not leak into it.
        p0 = pops;
        push(8'h3C);
        push(8'h77);
        @(negedge clk);
        scramble = 1'b1;
        refresh();
        repeat (84) @(negedge clk);
        check("iso_single_pop", pops - p0, 1);
        scramble = 1'b0;
        refresh();
        wait_idle(2 * FRAME_CYC + 20);
        check("iso_total_pops", pops - p0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
